ptltx_pulse_driver: RTL and testbench

- Clocked transmit end of the PTL link: serialises queued data words into a toggle-encoded pulse stream on `q`.
- Pulse encoding: each transmitted pulse is one transition of `q`, either rising or falling. This matches the PTL receiver's edge-triggered input convention.
- Sits between digital test/control logic and a PTL receiver input.
- Guarantees pulse spacing of at least one bit slot, so the receiver's critical timing window is never violated.

---
 rtl/ptltx_pkg.sv | 24 ++
 rtl/ptltx_word_fifo.sv | 54 +++++
 rtl/ptltx_pulse_driver.sv | 136 +++++++++++++
 tb/tb_ptltx_pulse_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ptltx_pkg.sv
// Shared types and helpers for the PTL transmit pulse driver.
// Frame length depends on PTLTX_PARITY_EN (adds one parity slot per frame).
package ptltx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Bit slots per transmitted word, including the parity slot when enabled.
  function automatic int frame_slots(input int width);
`ifdef PTLTX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ptltx_word_fifo.sv
// Word FIFO for the PTL transmitter: synchronous write, first-word fall-through
// read, pointer-plus-wrap-bit full/empty detection, asynchronous flush on rst.
module ptltx_word_fifo
  import ptltx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this push writes, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/ptltx_pulse_driver.sv
// PTL transmit end: serialises queued words LSB first as toggles on q, one bit
// slot of BIT_CYCLES clocks per bit. Optional PTLTX_PARITY_EN adds an odd-parity slot.
module ptltx_pulse_driver
  import ptltx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 2,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             q,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam int SC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LOAD  = SC_W'(1 % BIT_CYCLES);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(BIT_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(frame_slots(WIDTH) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef PTLTX_PARITY_EN
  localparam logic [IDX_W-1:0] IDX_PAR  = IDX_W'(WIDTH);
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] fifo_rdata;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] idx_next;
  logic [SC_W-1:0]  slot_cnt;
  logic [SC_W-1:0]  slot_cnt_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             slot_start;
  logic             slot_toggle;
  logic             frame_end;
  logic             toggle;
`ifdef PTLTX_PARITY_EN
  logic             par_toggle;
`endif

  ptltx_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign busy     = (state != IDLE) || !fifo_empty;

  // slot_cnt == 0 on an edge marks the first edge of the next bit slot.
  assign slot_start    = (slot_cnt == '0);
  assign slot_cnt_next = (slot_cnt == SC_MAX) ? '0 : slot_cnt + SC_ONE;
  assign idx_next      = slot_start ? bit_idx + IDX_ONE : bit_idx;
  assign sh_next       = shreg >> 1;
  // Leave a frame on its final cycle so a follow-on word pops exactly one slot later.
  assign frame_end     = (slot_cnt == SC_MAX) && (idx_next == IDX_LAST);

`ifdef PTLTX_PARITY_EN
  assign slot_toggle = slot_start && ((idx_next == IDX_PAR) ? par_toggle : sh_next[0]);
`else
  assign slot_toggle = slot_start && sh_next[0];
`endif

  assign toggle = (state == IDLE) ? (pop && fifo_rdata[0]) : slot_toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      slot_cnt  <= '0;
      q         <= 1'b0;
      pulse_cnt <= '0;
`ifdef PTLTX_PARITY_EN
      par_toggle <= 1'b0;
`endif
    end else begin
      if (toggle) begin
        q         <= ~q;
        pulse_cnt <= pulse_cnt + CNT_ONE;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= fifo_rdata;
            bit_idx  <= '0;
            slot_cnt <= SC_LOAD;
            state    <= SLOT;
`ifdef PTLTX_PARITY_EN
            par_toggle <= ~^fifo_rdata;
`endif
          end
        end
        SLOT, PAR: begin
          slot_cnt <= slot_cnt_next;
          if (slot_start) begin
            shreg   <= sh_next;
            bit_idx <= idx_next;
          end
          if (frame_end) begin
            state <= IDLE;
          end
`ifdef PTLTX_PARITY_EN
          else if (slot_start && (idx_next == IDX_PAR)) begin
            state <= PAR;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptltx_pulse_driver.sv
// Directed self-checking bench for ptltx_pulse_driver (WIDTH=8, BIT_CYCLES=2, DEPTH=4).
// Expected timings follow PTLTX_PARITY_EN when the macro is defined.
module tb_ptltx_pulse_driver;

  localparam int WIDTH = 8;
  localparam int BC    = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef PTLTX_PARITY_EN
  localparam int FL  = (WIDTH + 1) * BC;
  localparam bit PEN = 1'b1;
`else
  localparam int FL  = WIDTH * BC;
  localparam bit PEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             q;
  logic             busy;
  logic [CNT_W-1:0] pulse_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tog_q[$];
  logic q_prev = 1'b0;

  ptltx_pulse_driver #(
    .WIDTH      (WIDTH),
    .BIT_CYCLES (BC),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .q         (q),
    .busy      (busy),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  // cyc == E once rising edge E has completed.
  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge number of every q transition.
  always @(posedge clk) begin
    #1;
    if (q !== q_prev) tog_q.push_back(cyc);
    q_prev = q;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_tog(input string tag, input int exp[$]);
    check({tag, "_count"}, tog_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check({tag, "_edge"}, (i < tog_q.size()) ? tog_q[i] : -1, exp[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tog_q.delete();
  endtask

  // Offer w from the next falling edge; n returns the rising edge that accepted it.
  task automatic send(input logic [WIDTH-1:0] w, output int n);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("send_accept", (guard < 200), 1);
    n = cyc + 1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_after(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    int n, n1, n2, m, mn;
    int nw[6];
    int exp[$];

    // Reset state and a single 0x01 word.
    do_reset();
    check("rst_q", q, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulse_cnt", pulse_cnt, 0);
    send(8'h01, n);
    wait_after(n + FL - 1);
    check("w01_busy_last", busy, 1);
    wait_after(n + FL);
    check("w01_busy_done", busy, 0);
    wait_after(n + FL + 4);
    exp = {n + 1};
    check_tog("w01", exp);
    check("w01_pulse_cnt", pulse_cnt, 1);
    check("w01_q", q, 1);

    // 0xFF: a pulse every slot.
    do_reset();
    send(8'hFF, n);
    wait_after(n + FL + 4);
    exp.delete();
    for (int k = 0; k < 8; k++) exp.push_back(n + 1 + 2 * k);
    if (PEN) exp.push_back(n + 17);
    check_tog("wff", exp);
    check("wff_q", q, PEN ? 1 : 0);
    check("wff_pulse_cnt", pulse_cnt, PEN ? 9 : 8);
    mn = 1000;
    for (int i = 1; i < tog_q.size(); i++)
      if (tog_q[i] - tog_q[i-1] < mn) mn = tog_q[i] - tog_q[i-1];
    check("wff_min_spacing", mn, 2);

    // Back-to-back 0x80 then 0x01: no idle gap between frames.
    do_reset();
    send(8'h80, n1);
    send(8'h01, n2);
    check("b2b_accept_edges", n2, n1 + 1);
    wait_after(n1 + FL);
    check("b2b_busy_between", busy, 1);
    wait_after(n1 + 2 * FL + 2);
    check("b2b_busy_done", busy, 0);
    exp = {n1 + 15, n1 + FL + 1};
    check_tog("b2b", exp);
    check("b2b_pulse_cnt", pulse_cnt, 2);

    // Fill the FIFO while frame 1 runs; sixth offer must wait for a pop.
    do_reset();
    for (int k = 0; k < 5; k++) send(8'(1 << k), nw[k]);
    check("fill_accept_edges", nw[4], nw[0] + 4);
    check("fill_in_ready_full", in_ready, 0);
    check("fill_busy", busy, 1);
    send(8'h20, nw[5]);
    check("fill_sixth_edge", nw[5], nw[0] + FL + 2);
    wait_after(nw[0] + 6 * FL + 3);
    exp.delete();
    for (int k = 0; k < 6; k++) exp.push_back(nw[0] + 1 + FL * k + 2 * k);
    check_tog("fill", exp);
    check("fill_pulse_cnt", pulse_cnt, 6);
    check("fill_busy_done", busy, 0);
    check("fill_q", q, 0);

    // Reset during the third slot of 0xFF with 0x55 queued.
    do_reset();
    send(8'hFF, n);
    send(8'h55, n2);
    wait_after(n + 5);
    check("abort_pre_q", q, 1);
    check("abort_pre_cnt", pulse_cnt, 3);
    rst = 1'b1;
    #1;
    check("abort_q", q, 0);
    check("abort_cnt", pulse_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tog_q.delete();
    send(8'h03, m);
    wait_after(m + FL - 1);
    check("w03_busy_last", busy, 1);
    wait_after(m + FL);
    check("w03_busy_done", busy, 0);
    wait_after(m + FL + 4);
    exp = {m + 1, m + 3};
    if (PEN) exp.push_back(m + 17);
    check_tog("w03", exp);
    check("w03_pulse_cnt", pulse_cnt, PEN ? 3 : 2);
    check("w03_q", q, PEN ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
